// File: rtl/thread_cmd_arbiter_pkg.sv
// Thread command arbiter package: widths, command codes,
// FSM state encoding and the timeout result code.
`include "thread_cmd_defs.sv"

package thread_cmd_arbiter_pkg;

    localparam int DATA_W = `DATA_SIZE;
    localparam int ADDR_W = `ADDR_SIZE;

    localparam logic [3:0] CMD_NULL = `THREAD_CMD_NULL;
    localparam logic [3:0] CMD_RUN  = `THREAD_CMD_RUN;
    localparam logic [3:0] CMD_STOP = `THREAD_CMD_STOP;
    localparam logic [3:0] CMD_GNS  = `THREAD_CMD_GET_NEXT_STATE;

    localparam logic [1:0] RSLT_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    function automatic logic cmd_legal(
        input logic [3:0] c
    );
        case (c)
            CMD_RUN,
            CMD_STOP,
            CMD_GNS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/thread_cmd_arbiter_if.sv
// CPU-side and manager-side bundle of the thread command arbiter;
// slave is the arbiter's view, master the surrounding system.
interface thread_cmd_arbiter_if
    import thread_cmd_arbiter_pkg::*;
#(
    parameter int CPU_QUANTITY = 4
);

    logic [CPU_QUANTITY-1:0]        req;
    logic [4*CPU_QUANTITY-1:0]      cmd;
    logic [DATA_W*CPU_QUANTITY-1:0] data_in;
    logic [ADDR_W*CPU_QUANTITY-1:0] addr_in;
    logic [CPU_QUANTITY-1:0]        gnt;
    logic [CPU_QUANTITY-1:0]        done;
    logic [1:0]                     rslt;
    logic [DATA_W-1:0]              data_out;

    logic [3:0]                     mgr_cmd;
    logic [DATA_W-1:0]              mgr_data;
    logic [ADDR_W-1:0]              mgr_addr;
    logic                           mgr_rdy;
    logic [1:0]                     mgr_rslt;
    logic [DATA_W-1:0]              mgr_data_in;

    modport slave (
        input  req, cmd, data_in, addr_in,
        input  mgr_rdy, mgr_rslt, mgr_data_in,
        output gnt, done, rslt, data_out,
        output mgr_cmd, mgr_data, mgr_addr
    );

    modport master (
        output req, cmd, data_in, addr_in,
        output mgr_rdy, mgr_rslt, mgr_data_in,
        input  gnt, done, rslt, data_out,
        input  mgr_cmd, mgr_data, mgr_addr
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after ptr,
// returned one-hot together with a valid flag.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic [PW:0]   sum;
    logic [PW-1:0] k;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        sum   = '0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            k = sum[PW-1:0];
            if (!valid && req[k]) begin
                gnt[k] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_cmd_defs.sv
// Shared thread-command header: bus widths and command codes
// seen by CPUs and the thread manager.
`ifndef THREAD_CMD_DEFS_SV
`define THREAD_CMD_DEFS_SV

`define DATA_SIZE 32
`define ADDR_SIZE 32

`define THREAD_CMD_NULL           4'h0
`define THREAD_CMD_RUN            4'h1
`define THREAD_CMD_STOP           4'h2
`define THREAD_CMD_GET_NEXT_STATE 4'h3

`endif

// File: rtl/thread_cmd_arbiter.sv
// Arbitrates CPU thread commands onto one thread manager port.
// Define THRD_ARB_TIMEOUT_EN to bound the wait for mgr_rdy.
module thread_cmd_arbiter
    import thread_cmd_arbiter_pkg::*;
#(
    parameter int CPU_QUANTITY   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_oe,
    thread_cmd_arbiter_if.slave bus
);

    localparam int N  = CPU_QUANTITY;
    localparam int PW = $clog2(N);

    if (CPU_QUANTITY < 2) begin : g_bad_cpu
        $error("CPU_QUANTITY must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t        state, state_n;
    logic [PW-1:0]     rr_ptr, rr_next;
    logic [PW-1:0]     idx, sel_idx;
    logic [N-1:0]      gnt_q, pick_gnt;
    logic              pick_vld;
    logic              tmo;
    logic [3:0]        lat_cmd, sel_cmd;
    logic [DATA_W-1:0] lat_data, sel_data;
    logic [ADDR_W-1:0] lat_addr, sel_addr;
    logic [1:0]        cap_rslt;
    logic [DATA_W-1:0] cap_data;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

    always_comb begin
        sel_cmd  = '0;
        sel_data = '0;
        sel_addr = '0;
        sel_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_cmd  = bus.cmd[4*i +: 4];
                sel_data = bus.data_in[DATA_W*i +: DATA_W];
                sel_addr = bus.addr_in[ADDR_W*i +: ADDR_W];
                sel_idx  = PW'(i);
            end
        end
    end

    assign rr_next = (idx == PW'(N-1)) ? '0 : idx + PW'(1);

`ifdef THRD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counts only ISSUE cycles still waiting on the manager.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (clk_oe) begin
            if (state == ST_ISSUE && !bus.mgr_rdy && !tmo)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else if (clk_oe)
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:
                if (pick_vld)
                    state_n = cmd_legal(sel_cmd) ? ST_ISSUE
                                                 : ST_DONE;
            ST_ISSUE:
                if (bus.mgr_rdy)
                    state_n = ST_CAPT;
                else if (tmo)
                    state_n = ST_DONE;
            ST_CAPT:
                state_n = ST_DONE;
            ST_DONE:
                state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end

    // Illegal commands skip the manager with a zero result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            idx      <= '0;
            gnt_q    <= '0;
            lat_cmd  <= '0;
            lat_data <= '0;
            lat_addr <= '0;
            cap_rslt <= '0;
            cap_data <= '0;
        end else if (clk_oe) begin
            unique case (state)
                ST_IDLE:
                    if (pick_vld) begin
                        gnt_q    <= pick_gnt;
                        idx      <= sel_idx;
                        lat_cmd  <= sel_cmd;
                        lat_data <= sel_data;
                        lat_addr <= sel_addr;
                        cap_rslt <= '0;
                        cap_data <= '0;
                    end
                ST_ISSUE:
                    if (!bus.mgr_rdy && tmo) begin
                        cap_rslt <= RSLT_TIMEOUT;
                        cap_data <= '0;
                    end
                ST_CAPT: begin
                    cap_rslt <= bus.mgr_rslt;
                    cap_data <= bus.mgr_data_in;
                end
                ST_DONE: begin
                    gnt_q  <= '0;
                    rr_ptr <= rr_next;
                end
                default: ;
            endcase
        end
    end

    wire in_done = (state == ST_DONE);

    assign bus.gnt      = gnt_q;
    assign bus.done     = in_done ? gnt_q : '0;
    assign bus.rslt     = in_done ? cap_rslt : '0;
    assign bus.data_out = in_done ? cap_data : '0;
    assign bus.mgr_cmd  = (state == ST_ISSUE) ? lat_cmd
                                              : CMD_NULL;
    assign bus.mgr_data = lat_data;
    assign bus.mgr_addr = lat_addr;

endmodule

// File: doc/thread_cmd_arbiter.md
THREAD_CMD_ARBITER -- requirements
Module: thread_cmd_arbiter

Interface
REQ-001 SHALL have parameter CPU_QUANTITY, default 4, number of CPU requesters sharing the thread manager.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum enabled cycles spent waiting for mgr_rdy (used only when REQ-030 is enabled).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 clk_oe  in  1  clock enable; when 0, all state holds.
REQ-007 req  in  CPU_QUANTITY  per-CPU request; bit i belongs to CPU i.
REQ-008 cmd  in  4*CPU_QUANTITY  per-CPU thread command; slice i is bits [4i+3:4i].
REQ-009 data_in  in  `DATA_SIZE*CPU_QUANTITY  per-CPU command data.
REQ-010 addr_in  in  `ADDR_SIZE*CPU_QUANTITY  per-CPU command address.
REQ-011 gnt  out  CPU_QUANTITY  one-hot grant; all zero when idle.
REQ-012 done  out  CPU_QUANTITY  one-cycle completion strobe for the granted CPU.
REQ-013 rslt  out  2  result returned with done.
REQ-014 data_out  out  `DATA_SIZE  result data returned with done.
REQ-015 mgr_cmd / mgr_data / mgr_addr  out  4 / `DATA_SIZE / `ADDR_SIZE  command, data and address to the thread manager.
REQ-016 mgr_rdy  in  1  thread manager is accepting commands (its control state is `CTL_CPU_CMD).
REQ-017 mgr_rslt / mgr_data_in  in  2 / `DATA_SIZE  thread manager result and data.

Function
REQ-018 SHALL implement the FSM IDLE -> ISSUE -> CAPT -> DONE -> IDLE; every transition requires clk_oe=1.
REQ-019 IDLE: if any req bit is set, SHALL grant the first set bit, searching round-robin from rr_ptr; on the same edge it SHALL latch that CPU's cmd/data/addr and set gnt.
REQ-020 Legal commands are `THREAD_CMD_RUN, `THREAD_CMD_STOP and `THREAD_CMD_GET_NEXT_STATE. Any other latched command SHALL go directly IDLE->DONE with rslt=0 and data_out=0, and SHALL NOT be issued to the manager.
REQ-021 ISSUE: SHALL drive the latched payload on mgr_cmd/mgr_data/mgr_addr and hold it until a cycle with mgr_rdy=1, then go to CAPT.
REQ-022 CAPT: SHALL drive mgr_cmd=`THREAD_CMD_NULL (4'h0), and SHALL register mgr_rslt and mgr_data_in (fixed 1-cycle manager latency).
REQ-023 DONE: for exactly one cycle, done[granted]=1 while rslt/data_out hold the captured values; it SHALL then clear gnt, set rr_ptr = granted+1 (wrapping CPU_QUANTITY-1 -> 0) and go to IDLE.
REQ-024 Latency for a legal command with mgr_rdy already high: grant to done = 3 enabled cycles.
REQ-025 req deasserted after grant: the operation SHALL complete anyway and done SHALL still pulse.
REQ-026 Requests arriving while not IDLE SHALL wait; no requester SHALL wait more than CPU_QUANTITY operations.
REQ-027 mgr_cmd SHALL be `THREAD_CMD_NULL in every state except ISSUE.
REQ-028 Outside DONE, rslt and data_out SHALL be 0.

Reset
REQ-029 While rst=0 (regardless of clk_oe): state=IDLE, rr_ptr=0, gnt=0, done=0, rslt=0, data_out=0, mgr_cmd=0, mgr_data=0, mgr_addr=0, latched payload=0. A reset during an operation SHALL abandon it with no done pulse.

Configuration
REQ-030 With THRD_ARB_TIMEOUT_EN defined: a counter SHALL count enabled cycles spent in ISSUE; on reaching TIMEOUT_CYCLES it SHALL go to DONE with rslt=2'b10 and data_out=0. Without the macro, there SHALL be no counter and ISSUE SHALL wait indefinitely.

Structure
REQ-031 Thread command codes, including `THREAD_CMD_NULL, SHALL live in the shared thread-command header. FSM state encodings and the timeout result code (2'b10) SHALL live in a shared package header.
REQ-032 The round-robin selector SHALL be the sub-module rr_pick (inputs: req vector and pointer; outputs: one-hot grant and valid).

Verification
REQ-033 Reset, then CPU0 req RUN with data=5 and addr=0x40, mgr_rdy=1, mgr_rslt=1, mgr_data_in=all-ones -> mgr_cmd=RUN one cycle; done[0] 3 cycles after grant; rslt=1; data_out=all-ones.
REQ-034 req=4'b1111 held continuously -> grant order 0,1,2,3,0; gnt always one-hot.
REQ-035 CPU2 cmd=4'hF -> done[2] 1 cycle after grant, rslt=0, mgr_cmd never non-NULL.
REQ-036 mgr_rdy=0 for 10 cycles, then 1 -> payload held stable the whole time; done after rdy. With THRD_ARB_TIMEOUT_EN and mgr_rdy stuck 0 -> done at cycle 16 of ISSUE, rslt=2'b10.
REQ-037 clk_oe=0 for 5 cycles in ISSUE -> all outputs frozen; resumes on clk_oe=1.
REQ-038 rst asserted in CAPT -> next cycle all outputs 0, state IDLE, no done pulse.
